button_conditioner: RTL and testbench

- Front-end conditioning stage for the reaction game's pushbuttons. Sits directly upstream of the game controller and its hit checker.
- Synchronizes, debounces and edge-detects the four game buttons plus the start button.
- Emits clean level and single-cycle press pulses.
- Also emits a registered one-hot-to-binary press code, so the hit checker can compare a single value against the random target instead of four raw inputs.

---
 rtl/button_conditioner.sv | 169 ++++++++++++++++
 tb/tb_button_conditioner.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/button_conditioner.sv
`timescale 1ns/1ps
// button_conditioner
//   Front-end conditioning for the reaction game's pushbuttons. Each of the
//   five buttons is synchronised (two flops), debounced by an independent
//   four-state FSM with a stability counter, and turned into a clean level
//   plus a single-cycle press pulse. A registered encoder then turns the
//   game-button pulses [3:0] into one press code for the hit checker.
//
// Ports:
//   clk          system clock
//   rst          asynchronous, active-high reset
//   btn_raw[4:0] raw buttons; [3:0] = game buttons 1-4, [4] = start
//   btn_level    debounced pressed level (1 = pressed)
//   btn_pulse    one-cycle pulse on each accepted press
//   press_valid  one-cycle strobe: exactly one game button newly pressed
//   press_code   index 0-3 of that button (valid with press_valid)
//   multi_press  one-cycle strobe: two or more game buttons pressed together
module button_conditioner #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 19,
  parameter bit ACTIVE_LOW      = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] btn_raw,
  output logic [4:0] btn_level,
  output logic [4:0] btn_pulse,
  output logic       press_valid,
  output logic [1:0] press_code,
  output logic       multi_press
);

  typedef enum logic [1:0] {
    RELEASED    = 2'd0,
    PRESS_CHK   = 2'd1,
    PRESSED     = 2'd2,
    RELEASE_CHK = 2'd3
  } btn_state_t;

  // A new level is accepted when the counter has reached this value and the
  // input is still at the new level.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  // Internally 1 = pressed regardless of board polarity.
  logic [4:0] btn_in;
  logic [4:0] sync1_reg;
  logic [4:0] sync2_reg;

  assign btn_in = btn_raw ^ {5{ACTIVE_LOW}};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_reg <= '0;
      sync2_reg <= '0;
    end else begin
      sync1_reg <= btn_in;
      sync2_reg <= sync1_reg;
    end
  end

  // Per-button debounce FSMs, fully independent of each other.
  generate
    for (genvar gi = 0; gi < 5; gi++) begin : g_btn
      btn_state_t       state_reg, state_next;
      logic [CNT_W-1:0] cnt_reg, cnt_next;
      logic             pulse_reg, pulse_next;
      logic             level_reg;

      always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        pulse_next = 1'b0;
        case (state_reg)
          RELEASED: begin
            if (sync2_reg[gi]) begin
              state_next = PRESS_CHK;
              cnt_next   = '0;
            end
          end
          PRESS_CHK: begin
            if (!sync2_reg[gi]) begin
              state_next = RELEASED;          // bounce: drop silently
            end else if (cnt_reg == CNT_LAST) begin
              state_next = PRESSED;
              pulse_next = 1'b1;              // only press path raises a pulse
            end else begin
              cnt_next = cnt_reg + CNT_W'(1);
            end
          end
          PRESSED: begin
            if (!sync2_reg[gi]) begin
              state_next = RELEASE_CHK;
              cnt_next   = '0;
            end
          end
          RELEASE_CHK: begin
            if (sync2_reg[gi]) begin
              state_next = PRESSED;           // release bounce: no new pulse
            end else if (cnt_reg == CNT_LAST) begin
              state_next = RELEASED;
            end else begin
              cnt_next = cnt_reg + CNT_W'(1);
            end
          end
          default: begin
            state_next = RELEASED;
            cnt_next   = '0;
          end
        endcase
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          state_reg <= RELEASED;
          cnt_reg   <= '0;
          pulse_reg <= 1'b0;
          level_reg <= 1'b0;
        end else begin
          state_reg <= state_next;
          cnt_reg   <= cnt_next;
          pulse_reg <= pulse_next;
          // Level follows the state being entered so it rises with the pulse.
          level_reg <= (state_next == PRESSED) || (state_next == RELEASE_CHK);
        end
      end

      assign btn_pulse[gi] = pulse_reg;
      assign btn_level[gi] = level_reg;
    end
  endgenerate

  // Encoder over the game buttons only; the start button is excluded.
  logic [2:0] game_cnt;
  logic [1:0] game_idx;
  logic       press_valid_reg;
  logic       multi_press_reg;
  logic [1:0] press_code_reg;

  always_comb begin
    game_cnt = '0;
    game_idx = '0;
    for (int i = 0; i < 4; i++) begin
      if (btn_pulse[i]) begin
        game_cnt = game_cnt + 3'd1;
        game_idx = 2'(i);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      press_valid_reg <= 1'b0;
      multi_press_reg <= 1'b0;
      press_code_reg  <= '0;
    end else begin
      press_valid_reg <= (game_cnt == 3'd1);
      multi_press_reg <= (game_cnt >= 3'd2);
      // Code only updates on an unambiguous single press, otherwise holds.
      if (game_cnt == 3'd1) begin
        press_code_reg <= game_idx;
      end
    end
  end

  assign press_valid = press_valid_reg;
  assign multi_press = multi_press_reg;
  assign press_code  = press_code_reg;

endmodule

// File: tb/tb_button_conditioner.sv
`timescale 1ns/1ps
module tb_button_conditioner;

  localparam int DEB = 4;
  localparam bit AL  = 1'b1;

  logic       clk;
  logic       rst;
  logic [4:0] btn_raw;
  logic [4:0] btn_level;
  logic [4:0] btn_pulse;
  logic       press_valid;
  logic [1:0] press_code;
  logic       multi_press;

  button_conditioner #(
    .DEBOUNCE_CYCLES(DEB),
    .CNT_W(19),
    .ACTIVE_LOW(AL)
  ) dut (
    .clk(clk),
    .rst(rst),
    .btn_raw(btn_raw),
    .btn_level(btn_level),
    .btn_pulse(btn_pulse),
    .press_valid(press_valid),
    .press_code(press_code),
    .multi_press(multi_press)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a button's accepted level flips once the (two-cycle
  // delayed) pressed sample has disagreed with it for DEB+1 consecutive edges.
  logic [4:0] m_s1, m_s2, m_lvl, m_pulse;
  int         m_run[5];
  logic       m_pv, m_mp;
  logic [1:0] m_pc;

  task automatic model_reset();
    m_s1 = '0; m_s2 = '0; m_lvl = '0; m_pulse = '0;
    for (int i = 0; i < 5; i++) m_run[i] = 0;
    m_pv = 1'b0; m_mp = 1'b0; m_pc = '0;
  endtask

  task automatic model_edge(input logic [4:0] raw);
    logic [4:0] np;
    int n;
    if (rst) begin
      model_reset();
    end else begin
      np = '0;
      for (int i = 0; i < 5; i++) begin
        if (m_s2[i] != m_lvl[i]) begin
          m_run[i]++;
          if (m_run[i] == DEB + 1) begin
            m_lvl[i] = ~m_lvl[i];
            m_run[i] = 0;
            if (m_lvl[i]) np[i] = 1'b1;
          end
        end else begin
          m_run[i] = 0;
        end
      end
      n = $countones(m_pulse[3:0]);
      m_pv = (n == 1);
      m_mp = (n >= 2);
      if (n == 1) begin
        for (int j = 0; j < 4; j++) if (m_pulse[j]) m_pc = 2'(j);
      end
      m_pulse = np;
      m_s2 = m_s1;
      m_s1 = raw ^ {5{AL}};
    end
  endtask

  task automatic check_model();
    chk("level", 32'(btn_level), 32'(m_lvl));
    chk("pulse", 32'(btn_pulse), 32'(m_pulse));
    chk("press_valid", 32'(press_valid), 32'(m_pv));
    chk("multi_press", 32'(multi_press), 32'(m_mp));
    chk("press_code", 32'(press_code), 32'(m_pc));
  endtask

  // Per-segment observations of the DUT.
  int         seg_pcyc, seg_pv, seg_mp;
  logic [4:0] seg_por;

  task automatic seg_clear();
    seg_pcyc = 0; seg_pv = 0; seg_mp = 0; seg_por = '0;
  endtask

  task automatic step(input logic [4:0] raw);
    btn_raw = raw;
    @(posedge clk);
    model_edge(raw);
    @(negedge clk);
    check_model();
    if (btn_pulse != 5'b0) seg_pcyc++;
    seg_por |= btn_pulse;
    if (press_valid) seg_pv++;
    if (multi_press) seg_mp++;
  endtask

  typedef struct {
    logic [4:0] raw;
    int         cycles;
    int         pcyc;
    logic [4:0] por;
    int         pv;
    int         mp;
    logic [1:0] code;
    logic [4:0] lvl;
  } vec_t;

  vec_t tbl[17];

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    bit seen;
    logic [4:0] r;
    int len;

    // raw is active-low: 1F = all released.
    tbl[0]  = '{5'h1F,  4, 0, 5'h00, 0, 0, 2'd0, 5'h00}; // idle
    tbl[1]  = '{5'h1B, 20, 1, 5'h04, 1, 0, 2'd2, 5'h04}; // clean press btn2
    tbl[2]  = '{5'h1F, 10, 0, 5'h00, 0, 0, 2'd2, 5'h00}; // release btn2
    tbl[3]  = '{5'h1E,  2, 0, 5'h00, 0, 0, 2'd2, 5'h00}; // btn0 bounce
    tbl[4]  = '{5'h1F,  1, 0, 5'h00, 0, 0, 2'd2, 5'h00};
    tbl[5]  = '{5'h1E,  2, 0, 5'h00, 0, 0, 2'd2, 5'h00};
    tbl[6]  = '{5'h1F,  1, 0, 5'h00, 0, 0, 2'd2, 5'h00};
    tbl[7]  = '{5'h1E, 10, 1, 5'h01, 1, 0, 2'd0, 5'h01}; // steady btn0
    tbl[8]  = '{5'h1F, 10, 0, 5'h00, 0, 0, 2'd0, 5'h00};
    tbl[9]  = '{5'h1D, 10, 1, 5'h02, 1, 0, 2'd1, 5'h02}; // hold btn1
    tbl[10] = '{5'h1F,  2, 0, 5'h00, 0, 0, 2'd1, 5'h02}; // release glitch
    tbl[11] = '{5'h1D, 10, 0, 5'h00, 0, 0, 2'd1, 5'h02};
    tbl[12] = '{5'h1F, 10, 0, 5'h00, 0, 0, 2'd1, 5'h00};
    tbl[13] = '{5'h15, 10, 1, 5'h0A, 0, 1, 2'd1, 5'h0A}; // btn1+btn3
    tbl[14] = '{5'h1F, 10, 0, 5'h00, 0, 0, 2'd1, 5'h00};
    tbl[15] = '{5'h0F, 10, 1, 5'h10, 0, 0, 2'd1, 5'h10}; // start
    tbl[16] = '{5'h1F, 10, 0, 5'h00, 0, 0, 2'd1, 5'h00};

    rst = 1'b1;
    btn_raw = 5'h1F;
    model_reset();
    seg_clear();
    repeat (2) @(negedge clk);
    chk("reset level", 32'(btn_level), 32'h0);
    chk("reset pulse", 32'(btn_pulse), 32'h0);
    chk("reset press_valid", 32'(press_valid), 32'h0);
    chk("reset multi_press", 32'(multi_press), 32'h0);
    chk("reset press_code", 32'(press_code), 32'h0);
    rst = 1'b0;

    for (int t = 0; t < 17; t++) begin
      seg_clear();
      for (int c = 0; c < tbl[t].cycles; c++) step(tbl[t].raw);
      chk($sformatf("seg%0d pulse_cycles", t), 32'(seg_pcyc), 32'(tbl[t].pcyc));
      chk($sformatf("seg%0d pulse_bits", t), 32'(seg_por), 32'(tbl[t].por));
      chk($sformatf("seg%0d press_valid_cnt", t), 32'(seg_pv), 32'(tbl[t].pv));
      chk($sformatf("seg%0d multi_press_cnt", t), 32'(seg_mp), 32'(tbl[t].mp));
      chk($sformatf("seg%0d press_code", t), 32'(press_code), 32'(tbl[t].code));
      chk($sformatf("seg%0d level", t), 32'(btn_level), 32'(tbl[t].lvl));
      $display("seg %0d raw=%b cycles=%0d pulses=%0d bits=%b pv=%0d mp=%0d code=%0d level=%b",
               t, tbl[t].raw, tbl[t].cycles, seg_pcyc, seg_por, seg_pv, seg_mp,
               press_code, btn_level);
    end

    // Reset two cycles into a btn3 debounce: aborted, nothing emerges.
    seg_clear();
    step(5'h17);
    step(5'h17);
    rst = 1'b1;
    model_reset();
    #1;
    chk("async rst level", 32'(btn_level), 32'h0);
    chk("async rst pulse", 32'(btn_pulse), 32'h0);
    chk("async rst pv", 32'(press_valid), 32'h0);
    chk("async rst code", 32'(press_code), 32'h0);
    repeat (3) step(5'h17);
    chk("no pulse in reset", 32'(seg_pcyc), 32'h0);
    rst = 1'b0;
    lat = 0;
    seen = 1'b0;
    for (int c = 1; c <= 30 && !seen; c++) begin
      step(5'h17);
      if (btn_pulse[3]) begin
        seen = 1'b1;
        lat = c;
      end
    end
    chk("post-reset pulse seen", 32'(seen), 32'h1);
    chk("post-reset latency", 32'(lat), 32'd7);
    $display("reset-abort: pulse after %0d edges following reset release", lat);
    repeat (10) step(5'h1F);

    // Randomised phase against the model, with occasional resets.
    for (int s = 0; s < 200; s++) begin
      seg_clear();
      r = 5'($urandom_range(0, 31));
      len = $urandom_range(1, 12);
      if ($urandom_range(0, 24) == 0) begin
        rst = 1'b1;
        model_reset();
        #1;
        check_model();
        repeat ($urandom_range(1, 2)) step(r);
        rst = 1'b0;
      end
      for (int c = 0; c < len; c++) step(r);
      $display("rand %0d raw=%b cycles=%0d pulses=%0d pv=%0d mp=%0d level=%b",
               s, r, len, seg_pcyc, seg_pv, seg_mp, btn_level);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
